// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern buffer and its serial load controller.
// The buffer geometry defaults here are the ones the pattern buffer is built with.
package pattern_pkg;

  localparam int DEF_BUFFER_SIZE  = 12;
  localparam int DEF_BUFFER_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Counter width that never collapses to zero bits for tiny geometries.
  function automatic int clog2_min1(input int v);
    int w;
    w = $clog2(v);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  localparam int DEF_BITCNT_W  = clog2_min1(DEF_BUFFER_WIDTH);
  localparam int DEF_BYTECNT_W = clog2_min1(DEF_BUFFER_SIZE + 1);

endpackage

// File: rtl/pattern_loader.sv
// Serial load controller for the pattern buffer scan chain: streams new bytes in
// MSB first while capturing the old chain contents, so every full load is a swap.
module pattern_loader
  import pattern_pkg::*;
#(
  parameter int BUFFER_SIZE  = DEF_BUFFER_SIZE,
  parameter int BUFFER_WIDTH = DEF_BUFFER_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [BUFFER_WIDTH-1:0] in_byte,
  output logic                    in_ready,
  output logic                    ssel,
  output logic                    sin,
  input  logic                    sout,
  output logic [BUFFER_WIDTH-1:0] rd_byte,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int BW = clog2_min1(BUFFER_WIDTH);
  localparam int CW = clog2_min1(BUFFER_SIZE + 1);

  localparam logic [BW-1:0] BIT_LAST  = BW'(BUFFER_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [CW-1:0] BYTE_LAST = CW'(BUFFER_SIZE - 1);
  localparam logic [CW-1:0] BYTE_ZERO = CW'(0);
  localparam logic [CW-1:0] BYTE_ONE  = CW'(1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [BUFFER_WIDTH-1:0] r_shreg;
  logic [BUFFER_WIDTH-1:0] r_rdreg;
  logic [BUFFER_WIDTH-1:0] r_rd_byte;
  logic [BW-1:0]           r_bitcnt;
  logic [CW-1:0]           r_bytecnt;
  logic                    r_ssel;
  logic                    r_rd_valid;
  logic                    r_done;

  logic                    w_in_ready;
  logic                    w_take;
  logic                    w_last_bit;
  logic                    w_final;
  logic                    w_enter_load;
  logic [BUFFER_WIDTH-1:0] w_rd_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A start coinciding with the done strobe is dropped, hence the r_done qualifier.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_take      = 1'b0;
    w_last_bit  = 1'b0;
    w_final     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !r_done) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_take      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_SHIFT: begin
        if (r_bitcnt == BIT_LAST) begin
          w_last_bit = 1'b1;
          if (r_bytecnt == BYTE_LAST) begin
            w_final     = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            // Offering the next byte on the last bit keeps the chain shifting without a bubble.
            w_in_ready = 1'b1;
            if (in_valid) begin
              w_take      = 1'b1;
              w_state_nxt = ST_SHIFT;
            end else begin
              w_state_nxt = ST_LOAD;
            end
          end
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_enter_load = (r_state == ST_IDLE) && (w_state_nxt == ST_LOAD);
  assign w_rd_next    = (r_rdreg << 1) | BUFFER_WIDTH'(sout);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shreg    <= '0;
      r_rdreg    <= '0;
      r_rd_byte  <= '0;
      r_bitcnt   <= BIT_ZERO;
      r_bytecnt  <= BYTE_ZERO;
      r_ssel     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_ssel     <= (w_state_nxt == ST_SHIFT);
      r_rd_valid <= w_last_bit;
      r_done     <= w_final;

      // The shift register empties to zero as it drains, so sin idles low outside SHIFT.
      if (w_take) begin
        r_shreg <= in_byte;
      end else if (r_state == ST_SHIFT) begin
        r_shreg <= r_shreg << 1;
      end else begin
        r_shreg <= r_shreg;
      end

      if (r_state == ST_SHIFT) begin
        r_rdreg <= w_rd_next;
      end else begin
        r_rdreg <= r_rdreg;
      end

      if (w_last_bit) begin
        r_rd_byte <= w_rd_next;
      end else begin
        r_rd_byte <= r_rd_byte;
      end

      if (w_take || w_last_bit) begin
        r_bitcnt <= BIT_ZERO;
      end else if (r_state == ST_SHIFT) begin
        r_bitcnt <= r_bitcnt + BIT_ONE;
      end else begin
        r_bitcnt <= r_bitcnt;
      end

      if (w_enter_load) begin
        r_bytecnt <= BYTE_ZERO;
      end else if (w_last_bit) begin
        r_bytecnt <= r_bytecnt + BYTE_ONE;
      end else begin
        r_bytecnt <= r_bytecnt;
      end
    end
  end

  assign ssel     = r_ssel;
  assign sin      = r_shreg[BUFFER_WIDTH-1];
  assign in_ready = w_in_ready;
  assign rd_byte  = r_rd_byte;
  assign rd_valid = r_rd_valid;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;

endmodule

// File: doc/pattern_loader.md
Name: pattern_loader

Overview:
- Serial load controller directly upstream of the pattern buffer.
- Accepts pattern bytes over a valid/ready stream and serialises them into the buffer's scan chain by driving its shift-select and serial-in pins.
- Captures the buffer's serial output during the load and returns the previous contents as readback bytes, so each load is a swap.
- While the loader is busy, the core must hold the buffer's field_write low.

Parameters:
- BUFFER_SIZE, 12, number of pattern fields in the buffer chain.
- BUFFER_WIDTH, 8, bits per field; also the byte width of in_byte and rd_byte.

Ports:
- clk  in  1  system clock, shared with the pattern buffer.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a full load.
- in_valid  in  1  in_byte is valid.
- in_byte  in  BUFFER_WIDTH  next pattern byte.
- in_ready  out  1  loader accepts in_byte on this edge.
- ssel  out  1  buffer shift enable; the buffer shifts on every edge where ssel=1.
- sin  out  1  serial data into the buffer chain.
- sout  in  1  serial data out of the buffer chain (last field, MSB).
- rd_byte  out  BUFFER_WIDTH  captured previous field contents.
- rd_valid  out  1  one-cycle strobe; rd_byte is valid.
- busy  out  1  load in progress.
- done  out  1  one-cycle strobe; load complete.

Behaviour:
- Reset: state IDLE. ssel, sin, in_ready, rd_valid, busy and done are all 0. rd_byte=0. All counters are 0.
- Reset mid-load aborts immediately. The buffer keeps its partially shifted contents; the loader does not restore them.
- ssel and sin are driven directly from flops, with no combinational path from inputs.
- Byte order:
  - The first byte accepted is the content for field BUFFER_SIZE-1; the last byte accepted is field 0.
  - Each byte is shifted MSB first.
  - After BUFFER_SIZE*BUFFER_WIDTH shifts, the field-k byte sits in field k.
- States: IDLE, LOAD (awaiting a byte), SHIFT.
- IDLE:
  - in_ready=0 and busy=0.
  - start=1 -> LOAD.
  - in_valid is ignored.
- LOAD:
  - busy=1, in_ready=1, ssel=0.
  - A handshake (in_valid & in_ready) copies in_byte into the shift register, clears bitcnt and moves to SHIFT.
  - The next cycle has ssel=1 and sin=in_byte[MSB].
- SHIFT:
  - ssel=1 and sin=shreg[MSB].
  - Each cycle: shreg shifts left, bitcnt increments, and the sout value present during the cycle (pre-shift) is shifted into rdreg at its LSB.
- Last bit of a byte (bitcnt=BUFFER_WIDTH-1):
  - rd_byte is loaded with the completed rdreg and rd_valid pulses the next cycle.
  - bytecnt increments.
- Last bit, bytecnt < BUFFER_SIZE-1:
  - in_ready=1 during this cycle.
  - On a handshake the next byte loads and SHIFT continues with no bubble, so fully streamed input gives BUFFER_SIZE*BUFFER_WIDTH consecutive ssel cycles.
  - Without a handshake -> LOAD, and ssel=0 from the next cycle.
- Last bit, bytecnt = BUFFER_SIZE-1:
  - in_ready=0.
  - Next cycle: IDLE, done=1 for one cycle (coincident with the final rd_valid), busy=0.
- Readback order: rd_byte strobes return the old field BUFFER_SIZE-1 first and field 0 last, MSB first within each byte.
- start while busy is ignored. A start in the same cycle as done is ignored.
- in_ready is never asserted in IDLE or in non-final SHIFT cycles.
- Counter widths:
  - bitcnt: $clog2(BUFFER_WIDTH), wraps to 0 after each byte.
  - bytecnt: $clog2(BUFFER_SIZE+1), cleared on entry to LOAD from IDLE.
- busy is high from the cycle after start until the cycle done asserts.
- Minimum load time: 1 + BUFFER_SIZE*BUFFER_WIDTH cycles from start to done-1 (97 cycles at defaults).

Decomposition:
- Shared package pattern_pkg holds:
  - the BUFFER_SIZE/BUFFER_WIDTH defaults, shared with the pattern buffer;
  - a state typedef (IDLE, LOAD, SHIFT);
  - the derived counter-width localparams.
- No sub-module. The shift/capture datapath and the FSM stay in one module.
- The bench instantiates the real pattern buffer as the load.

Test Plan:
- Reset with buffer preloaded 0x00..0x0B in fields 0..11; start, stream 0xA0..0xAB with in_valid held -> ssel high 96 consecutive cycles; fields 11..0 = 0xA0..0xAB; rd_byte sequence 0x0B,0x0A,..,0x00; done once.
- Same load with in_valid dropped for 5 cycles after byte 3 -> ssel=0 for exactly those stall cycles plus the LOAD cycle; final buffer contents identical.
- Two back-to-back loads, 0x55 then 0xC3 in all fields -> second load's rd_byte all 0x55; buffer ends all 0xC3.
- start pulsed mid-load and in_valid asserted in IDLE -> no effect; byte count and ssel pattern unchanged.
- reset_n low for 1 cycle after 40 shifts -> next cycle all outputs 0, state IDLE; a subsequent full load completes normally with correct readback of partially shifted contents.
- Single-bit marker: buffer all 0 except field 11 = 0x80 -> first rd_byte = 0x80, rd_valid on cycle 9 after the first handshake.
